matrix_sub_sequencer: RTL and testbench
=======================================

Name: matrix_sub_sequencer

Overview:
- Time-multiplexes one element subtractor across a ROWS x COLS matrix, computing C = A - B element by element.
- Element pairs (a, b) arrive serially over a valid/ready stream, in row-major order.
- The block buffers the differences and presents the whole result matrix as one flat word with per-element borrow flags.
- It is the serial, area-reduced alternative to the fully parallel 9-element matrix subtractor, and sits between the operand-fetch stream and the result consumer.

Parameters:
- DW, 16, element width in bits.
- ROWS, 3, matrix rows.
- COLS, 3, matrix columns; N = ROWS*COLS (9 by default).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  element pair valid.
- in_ready  out  1  block can accept an element pair.
- in_a  in  DW  minuend element.
- in_b  in  DW  subtrahend element.
- in_last  in  1  marks the final element (index N-1) of a matrix.
- out_valid  out  1  result matrix valid.
- out_ready  in  1  consumer accepts the result.
- out_c  out  N*DW  result matrix; element k occupies bits [k*DW +: DW], k = row*COLS + col.
- out_borrow  out  N  bit k = 1 when in_a < in_b (unsigned) for element k.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Clocking: clk only; rst is synchronous and active-high and dominates all other inputs.
- State machine: two states, LOAD and DONE; reset enters LOAD.
- Reset values: count=0, out_valid=0, out_c=0, out_borrow=0, frame_err=0.
- in_ready is 1 exactly when state==LOAD and rst==0; it is 0 while rst is high.
- Arithmetic: diff = (in_a - in_b) mod 2^DW (two's-complement wrap). borrow = (in_a < in_b), unsigned compare.

LOAD state:
- An element is accepted when in_valid && in_ready.
- On accept, the buffer entry at index count is written with diff and borrow.
- count increments; it wraps to 0 only on frame completion or on a framing error.
- Accept with count==N-1 and in_last==1: go to DONE; out_valid=1 on the next cycle (result latency is 1 cycle after the last accept); count returns to 0.
- Framing error, either case:
  - in_last==1 with count<N-1;
  - in_last==0 with count==N-1.
- On a framing error:
  - frame_err pulses for 1 cycle;
  - the partial frame is discarded and count returns to 0;
  - state stays LOAD;
  - out_c and out_borrow hold their previous values.

DONE state:
- out_valid is held at 1 and out_c/out_borrow are held stable until out_valid && out_ready.
- On transfer: out_valid drops to 0 the next cycle and the state returns to LOAD.
- No overlap between result and input: in_ready=0 throughout DONE. Minimum throughput is N+1 cycles per matrix.
- out_ready is ignored while out_valid==0.

Other rules:
- in_valid without in_ready has no effect; the producer holds in_a, in_b and in_last stable.
- Reset mid-frame or mid-DONE: the partial frame and any pending result are dropped; all values return to reset.

Optional Feature:
- Macro: MATRIX_SUB_SAT_EN.
- Defined: an element with borrow=1 stores 0 (unsigned saturate at floor) instead of the wrapped diff; out_borrow still reports the borrow.
- Undefined: wrapped diff is stored. Ports are identical in both builds.

Decomposition:
- Package matrix_sub_pkg holds:
  - DW, ROWS, COLS and N defaults;
  - the state enum {LOAD, DONE};
  - the count width, clog2(N).
- One sub-module, matrix_sub_elem_unit: combinational DW-bit subtractor returning diff and borrow, with saturation under MATRIX_SUB_SAT_EN.
- The sequencer instantiates matrix_sub_elem_unit exactly once and owns the FSM, counter and result buffer.

Test Plan:
- Basic frame: a_k = 100+k, b_k = k for k=0..8, in_last on k=8, out_ready=1 → out_valid rises 1 cycle after the 9th accept; every element = 100; out_borrow = 0; frame_err never pulses.
- Borrow/wrap: a=0x0003, b=0x0005 at k=4 → element 4 = 0xFFFE and out_borrow[4]=1. With MATRIX_SUB_SAT_EN defined, element 4 = 0x0000 and out_borrow[4]=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_valid and out_c stable, in_ready=0; raising out_ready transfers, in_ready=1 the next cycle, and the next frame is accepted.
- Early in_last at k=5 → frame_err pulses 1 cycle, no out_valid; the following clean 9-element frame completes with correct values.
- Missing in_last at k=8 → frame_err pulses; next frame correct.
- Reset after 4 accepts → in_ready=0 during rst; after release, a full 9-element frame yields correct out_c with no residue from the aborted frame.

Source files
------------

// File: rtl/matrix_sub_pkg.sv
// Shared defaults, state encoding and counter width for the serial matrix subtractor.
package matrix_sub_pkg;

  localparam int unsigned DEF_DW   = 16;
  localparam int unsigned DEF_ROWS = 3;
  localparam int unsigned DEF_COLS = 3;
  localparam int unsigned DEF_N    = DEF_ROWS * DEF_COLS;
  localparam int unsigned CNT_W    = (DEF_N > 1) ? $clog2(DEF_N) : 1;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/matrix_sub_elem_unit.sv
// Combinational DW-bit element subtractor with unsigned borrow.
// MATRIX_SUB_SAT_EN: a borrowing element clamps to zero instead of wrapping.
module matrix_sub_elem_unit
  import matrix_sub_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_diff,
  output logic          o_borrow
);

  logic [DW-1:0] w_raw;

  assign w_raw    = i_a - i_b;
  assign o_borrow = (i_a < i_b);

`ifdef MATRIX_SUB_SAT_EN
  assign o_diff = o_borrow ? '0 : w_raw;
`else
  assign o_diff = w_raw;
`endif

endmodule

// File: rtl/matrix_sub_sequencer.sv
// Serial ROWS x COLS matrix subtractor: one element per accept, whole result presented at once.
// Build option MATRIX_SUB_SAT_EN selects floor-saturation in the element unit.
module matrix_sub_sequencer
  import matrix_sub_pkg::*;
#(
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned COLS = DEF_COLS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_a,
  input  logic [DW-1:0]           in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROWS*COLS*DW-1:0] out_c,
  output logic [ROWS*COLS-1:0]    out_borrow,
  output logic                    frame_err
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [N*DW-1:0] r_buf;
  logic [N-1:0]    r_buf_bor;
  logic [N*DW-1:0] r_out_c;
  logic [N-1:0]    r_out_bor;
  logic            r_out_valid;
  logic            r_frame_err;

  logic [DW-1:0]   w_diff;
  logic            w_borrow;
  logic            w_accept;
  logic            w_at_end;
  logic            w_complete;
  logic            w_ferr;
  logic [N*DW-1:0] w_final_c;
  logic [N-1:0]    w_final_bor;

  matrix_sub_elem_unit #(.DW(DW)) u_elem (
    .i_a      (in_a),
    .i_b      (in_b),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  assign in_ready   = (r_state == LOAD) && !rst;
  assign out_valid  = r_out_valid;
  assign out_c      = r_out_c;
  assign out_borrow = r_out_bor;
  assign frame_err  = r_frame_err;

  // Accept/framing decode and next state; the last element bypasses the buffer into the result.
  always_comb begin
    w_at_end    = (r_count == CW'(N - 1));
    w_accept    = in_valid && in_ready;
    w_complete  = w_accept && in_last && w_at_end;
    w_ferr      = w_accept && (in_last != w_at_end);
    w_final_c   = r_buf;
    w_final_bor = r_buf_bor;
    w_final_c[(N-1)*DW +: DW] = w_diff;
    w_final_bor[N-1]          = w_borrow;
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_complete) w_state_nxt = DONE;
      DONE:    if (r_out_valid && out_ready) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_buf       <= '0;
      r_buf_bor   <= '0;
      r_out_c     <= '0;
      r_out_bor   <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      if (w_accept) begin
        if (w_complete || w_ferr) r_count <= '0;
        else                      r_count <= r_count + 1'b1;
        for (int k = 0; k < N; k++) begin
          if (r_count == CW'(k)) begin
            r_buf[k*DW +: DW] <= w_diff;
            r_buf_bor[k]      <= w_borrow;
          end
        end
      end
      // Result registers only change on a clean frame, so a framing error leaves them intact.
      if (w_complete) begin
        r_out_c     <= w_final_c;
        r_out_bor   <= w_final_bor;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_sub_sequencer.sv
// Directed, table-driven bench for matrix_sub_sequencer (honours MATRIX_SUB_SAT_EN).
module tb_matrix_sub_sequencer;

  localparam int DW = 16;
  localparam int N  = 9;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] out_c;
  logic [N-1:0]    out_borrow;
  logic            frame_err;

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    logic        ferr;
  } vec_t;

  vec_t            tv[$];
  int              n_chk;
  int              n_fail;
  logic [N*DW-1:0] exp_c;
  logic [N-1:0]    exp_bor;
  logic [N*DW-1:0] committed_c;
  logic [N-1:0]    committed_bor;

  matrix_sub_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_c      (out_c),
    .out_borrow (out_borrow),
    .frame_err  (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] ref_diff(input logic [15:0] a, input logic [15:0] b);
`ifdef MATRIX_SUB_SAT_EN
    if (a < b) return 16'h0000;
`endif
    return 16'(a - b);
  endfunction

  task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic [15:0] a, input logic [15:0] b,
                      input logic last, input logic ferr);
    vec_t v;
    v.idx = idx; v.a = a; v.b = b; v.last = last; v.ferr = ferr;
    tv.push_back(v);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    int t;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send(tv[i].a, tv[i].b, tv[i].last);
      exp_c[tv[i].idx*DW +: DW] = ref_diff(tv[i].a, tv[i].b);
      exp_bor[tv[i].idx]        = (tv[i].a < tv[i].b);
      chk("frame_err", frame_err, tv[i].ferr);
      if (tv[i].last && !tv[i].ferr) begin
        chk("out_valid_rise", out_valid, 1);
        chk("out_c", out_c, exp_c);
        chk("out_borrow", out_borrow, exp_bor);
        committed_c   = exp_c;
        committed_bor = exp_bor;
        if (out_ready) begin
          chk("in_ready_done", in_ready, 0);
          @(posedge clk);
          #1;
          chk("out_valid_drop", out_valid, 0);
          chk("in_ready_back", in_ready, 1);
        end
      end else begin
        chk("out_valid_idle", out_valid, 0);
        chk("out_c_hold", out_c, committed_c);
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    exp_c = '0; exp_bor = '0; committed_c = '0; committed_bor = '0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;

    // 0..8 basic, 9..17 borrow at k=4, 18..23 early last, 24..32 clean with wrap extremes,
    // 33..41 missing last, 42..50 clean
    for (int k = 0; k < 9; k++) push(k, 16'(100 + k), 16'(k), k == 8, 1'b0);
    for (int k = 0; k < 9; k++)
      if (k == 4) push(k, 16'h0003, 16'h0005, 1'b0, 1'b0);
      else        push(k, 16'(1000 + 7 * k), 16'(k), k == 8, 1'b0);
    for (int k = 0; k < 6; k++) push(k, 16'(500 + k), 16'(3 * k), k == 5, k == 5);
    push(0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) push(k, 16'(k * k + 50), 16'(k), 1'b0, 1'b0);
    push(8, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) push(k, 16'(40 + k), 16'(2 * k), 1'b0, k == 8);
    for (int k = 0; k < 9; k++) push(k, 16'(2 * k + 7), 16'(k), k == 8, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_c", out_c, 0);
    chk("rst_out_borrow", out_borrow, 0);
    chk("rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    apply(0, 50);

    // Backpressure: result must hold while out_ready is low, and input is ignored meanwhile
    out_ready = 1'b0;
    apply(0, 8);
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0001; in_last = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_c", out_c, committed_c);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_frame_err", frame_err, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_xfer_valid", out_valid, 0);
    chk("bp_xfer_ready", in_ready, 1);
    chk("bp_xfer_hold", out_c, committed_c);
    apply(42, 50);

    // Reset mid-frame after four accepts
    apply(0, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_c", out_c, 0);
    chk("midrst_out_borrow", out_borrow, 0);
    @(negedge clk);
    rst = 1'b0;
    committed_c = '0; committed_bor = '0;
    apply(24, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
